// File: rtl/serv_trace_ctrl.sv
// SERV retire trace controller: queues retired-instruction records in a small
// FIFO and serialises each one as a 9-byte frame on a valid/ready byte stream.
module serv_trace_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_ret_valid,
  input  logic [31:0] i_ret_pc,
  input  logic [31:0] i_ret_insn,
  input  logic        i_ret_trap,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  input  logic        i_drop_clr,
  output logic [7:0]  o_drop_cnt,
  output logic        o_busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  // Record layout: [65] lost, [64] trap, [63:32] pc, [31:0] insn
  logic [65:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          lost;
  state_t        state;
  logic [3:0]    idx;

  logic retire, full, push, drop, accept, pop;

  assign retire = i_ret_valid & i_en;
  assign full   = (count == FULL_CNT);
  assign push   = retire & ~full;
  assign drop   = retire & full;
  assign accept = o_tx_valid & i_tx_ready;
  assign pop    = accept & (idx == 4'd8);
  assign o_busy = (count != '0) | (state == SEND);

  function automatic logic [7:0] frame_byte(input logic [65:0] r, input logic [3:0] k);
    logic [7:0] b;
    case (k)
      4'd0:    b = {6'b101000, r[65], r[64]};
      4'd1:    b = r[39:32];
      4'd2:    b = r[47:40];
      4'd3:    b = r[55:48];
      4'd4:    b = r[63:56];
      4'd5:    b = r[7:0];
      4'd6:    b = r[15:8];
      4'd7:    b = r[23:16];
      4'd8:    b = r[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Record storage: intentionally not reset; count gating keeps stale slots unread
  always_ff @(posedge i_clk) begin
    if (push) mem[wptr] <= {lost, i_ret_trap, i_ret_pc, i_ret_insn};
  end

  // FIFO pointers, occupancy and lost flag; fullness is judged before any same-cycle pop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      lost  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push)      lost <= 1'b0;
      else if (drop) lost <= 1'b1;
    end
  end

  // Saturating drop counter; a clear coinciding with a drop leaves a count of one
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_drop_cnt <= '0;
    end else if (i_drop_clr) begin
      o_drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop && o_drop_cnt != '1) begin
      o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end

  // Frame FSM with registered byte/valid; the next byte is preloaded on each accept
  // so consecutive queued frames stream with no idle gap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state      <= SEND;
            idx        <= '0;
            o_tx_valid <= 1'b1;
            o_tx_data  <= frame_byte(mem[rptr], 4'd0);
          end
        end
        SEND: begin
          if (accept) begin
            if (idx != 4'd8) begin
              idx       <= idx + 4'd1;
              o_tx_data <= frame_byte(mem[rptr], idx + 4'd1);
            end else begin
              idx <= '0;
              if (count > (AW + 1)'(1)) begin
                o_tx_data <= frame_byte(mem[rptr + 1'b1], 4'd0);
              end else begin
                state      <= IDLE;
                o_tx_valid <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_trace_ctrl.sv
// Self-checking bench for serv_trace_ctrl: queue-based reference model plus
// directed scenarios with literal expectations and a randomized soak.
module tb_serv_trace_ctrl;

  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_en = 1'b0;
  logic        i_ret_valid = 1'b0;
  logic [31:0] i_ret_pc = '0;
  logic [31:0] i_ret_insn = '0;
  logic        i_ret_trap = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b0;
  logic        i_drop_clr = 1'b0;
  logic [7:0]  o_drop_cnt;
  logic        o_busy;

  serv_trace_ctrl #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_ret_valid(i_ret_valid),
    .i_ret_pc(i_ret_pc), .i_ret_insn(i_ret_insn), .i_ret_trap(i_ret_trap),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .i_drop_clr(i_drop_clr), .o_drop_cnt(o_drop_cnt), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        lost;
    logic        trap;
    logic [31:0] pc;
    logic [31:0] insn;
  } rec_t;

  rec_t mq[$];
  bit   m_lost;
  int   m_drops;
  bit   m_send;
  int   m_idx;
  int   m_n;
  bit   m_full;
  bit   m_ret;
  rec_t m_tmp;

  function automatic logic [7:0] fbyte(input rec_t r, input int k);
    if (k == 0) return 8'hA0 | {6'b0, r.lost, r.trap};
    else if (k < 5) return 8'(r.pc >> (8 * (k - 1)));
    else return 8'(r.insn >> (8 * (k - 5)));
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mq.delete();
      m_lost = 0; m_drops = 0; m_send = 0; m_idx = 0;
    end else begin
      m_n    = mq.size();
      m_full = (m_n == DEPTH);
      m_ret  = i_ret_valid && i_en;
      if (!m_send) begin
        if (m_n > 0) begin m_send = 1; m_idx = 0; end
      end else if (i_tx_ready) begin
        if (m_idx < 8) m_idx++;
        else begin
          void'(mq.pop_front());
          m_idx  = 0;
          m_send = (m_n > 1);
        end
      end
      if (m_ret && !m_full) begin
        m_tmp.lost = m_lost; m_tmp.trap = i_ret_trap;
        m_tmp.pc = i_ret_pc; m_tmp.insn = i_ret_insn;
        mq.push_back(m_tmp);
        m_lost = 0;
      end else if (m_ret) begin
        m_lost = 1;
      end
      if (i_drop_clr) m_drops = (m_ret && m_full) ? 1 : 0;
      else if (m_ret && m_full && m_drops < 255) m_drops++;
    end
  end

  // Every-cycle comparison against the model, plus a log of accepted bytes
  logic [7:0] acc[$];

  always @(negedge i_clk) begin
    chk("tx_valid", o_tx_valid, m_send);
    chk("busy", o_busy, (mq.size() > 0) || m_send);
    chk("drop_cnt", o_drop_cnt, m_drops);
    if (m_send && o_tx_valid) chk("tx_data", o_tx_data, fbyte(mq[0], m_idx));
    if (o_tx_valid && i_tx_ready) acc.push_back(o_tx_data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic trap);
    i_ret_valid = 1; i_ret_pc = pc; i_ret_insn = insn; i_ret_trap = trap;
    tick();
    i_ret_valid = 0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (o_busy && k < budget) begin tick(); k++; end
    if (o_busy) chk("idle_timeout", 1, 0);
  endtask

  logic [7:0] exp28 [9];
  logic [7:0] exp29 [9];
  int run;

  initial begin
    exp28 = '{8'hA0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
    exp29 = '{8'hA1, 8'h11, 8'h22, 8'h33, 8'h44, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    // Reset state
    tick(); tick();
    chk("rst_valid", o_tx_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_drop", o_drop_cnt, 0);
    i_rst_n = 1; i_en = 1; i_tx_ready = 1;
    tick();

    // Single retire: latency and byte order
    acc.delete();
    retire(32'h0000_0100, 32'h0050_0093, 0);
    chk("e0_valid", o_tx_valid, 0);
    chk("e0_busy", o_busy, 1);
    tick();
    chk("e1_valid", o_tx_valid, 1);
    chk("e1_header", o_tx_data, 8'hA0);
    wait_idle(50);
    chk("single_len", acc.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < acc.size()) chk($sformatf("single_b%0d", i), acc[i], exp28[i]);
    chk("single_busy_end", o_busy, 0);

    // Backpressure at byte 3
    acc.delete();
    retire(32'h4433_2211, 32'hDEAD_BEEF, 1);
    for (int i = 0; i < 50 && acc.size() < 3; i++) tick();
    i_tx_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", o_tx_valid, 1);
      chk("bp_hold", o_tx_data, 8'h33);
    end
    i_tx_ready = 1;
    wait_idle(50);
    chk("bp_len", acc.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < acc.size()) chk($sformatf("bp_b%0d", i), acc[i], exp29[i]);

    // Overflow: 6 retires into a depth-4 FIFO with the sink stalled
    i_tx_ready = 0;
    for (int i = 0; i < 6; i++) begin
      i_ret_valid = 1; i_ret_pc = 32'h1000 + 4 * i; i_ret_insn = 32'h13; i_ret_trap = 0;
      tick();
    end
    i_ret_valid = 0;
    chk("ovf_drops", o_drop_cnt, 2);
    acc.delete();
    i_tx_ready = 1;
    wait_idle(100);
    chk("ovf_len", acc.size(), 36);
    for (int f = 0; f < 4; f++)
      if (9 * f < acc.size()) chk("ovf_hdr", acc[9 * f], 8'hA0);
    retire(32'h2000, 32'h13, 0);
    wait_idle(50);
    if (acc.size() > 36) chk("lost_hdr", acc[36], 8'hA2);
    else chk("lost_len", acc.size(), 45);

    // Drop counter saturation and coincident clear
    i_tx_ready = 0;
    i_ret_valid = 1;
    for (int i = 0; i < 310; i++) tick();
    chk("sat_drops", o_drop_cnt, 255);
    i_drop_clr = 1;
    tick();
    chk("clr_with_drop", o_drop_cnt, 1);
    i_ret_valid = 0;
    tick();
    chk("clr_only", o_drop_cnt, 0);
    i_drop_clr = 0;
    i_tx_ready = 1;
    wait_idle(100);

    // Reset mid-frame at byte 4
    acc.delete();
    retire(32'h0000_0100, 32'h0050_0093, 0);
    for (int i = 0; i < 50 && acc.size() < 4; i++) tick();
    i_rst_n = 0;
    #1;
    chk("midrst_valid", o_tx_valid, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_data", o_tx_data, 0);
    tick();
    i_rst_n = 1;
    run = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (o_tx_valid) run++; end
    chk("post_rst_quiet", run, 0);

    // Back-to-back: three queued frames stream without gaps
    i_tx_ready = 0;
    for (int i = 0; i < 3; i++) retire(32'h3000 + i, 32'h5000 + i, i[0]);
    acc.delete();
    i_tx_ready = 1;
    run = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge i_clk);
      if (o_tx_valid) run++;
      else if (run > 0) break;
    end
    chk("b2b_run", run, 27);
    tick();
    wait_idle(50);
    chk("b2b_len", acc.size(), 27);

    // Randomized soak against the model
    for (int i = 0; i < 3000; i++) begin
      i_en        = ($urandom % 4) != 0;
      i_ret_valid = ($urandom % 3) == 0;
      i_ret_pc    = $urandom;
      i_ret_insn  = $urandom;
      i_ret_trap  = ($urandom % 5) == 0;
      i_tx_ready  = ($urandom % 4) != 0;
      i_drop_clr  = ($urandom % 60) == 0;
      tick();
    end
    i_ret_valid = 0; i_drop_clr = 0; i_tx_ready = 1;
    wait_idle(200);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serv_trace_ctrl.md
SERV_TRACE_CTRL -- requirements
Module: serv_trace_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, retire-record FIFO depth in entries; power of two, 2..16.
REQ-002 SHALL have port i_clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port i_rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_en  in  1  capture enable; retires are ignored while low.
REQ-005 SHALL have port i_ret_valid  in  1  one-cycle pulse, instruction retired.
REQ-006 SHALL have port i_ret_pc  in  32  PC of retired instruction.
REQ-007 SHALL have port i_ret_insn  in  32  instruction word of retired instruction.
REQ-008 SHALL have port i_ret_trap  in  1  retired instruction trapped.
REQ-009 SHALL have port o_tx_data  out  8  trace byte stream.
REQ-010 SHALL have port o_tx_valid  out  1  o_tx_data valid.
REQ-011 SHALL have port i_tx_ready  in  1  sink accepts byte.
REQ-012 SHALL have port i_drop_clr  in  1  clear drop counter.
REQ-013 SHALL have port o_drop_cnt  out  8  saturating count of dropped records.
REQ-014 SHALL have port o_busy  out  1  high when FIFO non-empty or a frame is in progress.

Function
REQ-015 SHALL, on i_ret_valid & i_en with FIFO not full at that edge, write record {lost, trap, pc, insn} at the tail; lost = current lost flag, which is then cleared.
REQ-016 SHALL, on i_ret_valid & i_en with FIFO full, drop the record, set the lost flag, and increment o_drop_cnt, saturating at 255.
REQ-017 SHALL evaluate fullness before any same-cycle pop; a frame completing in the same cycle does not free a slot for that retire.
REQ-018 SHALL clear o_drop_cnt to 0 on i_drop_clr; if a drop occurs in the same cycle, o_drop_cnt becomes 1.
REQ-019 SHALL serialise each entry as a 9-byte frame: byte0 = {6'b101000, lost, trap}; bytes 1-4 = pc, LSB first; bytes 5-8 = insn, LSB first.
REQ-020 SHALL implement FSM IDLE/SEND with 4-bit byte index 0..8.
- IDLE: go to SEND with index 0 when the FIFO is non-empty.
- SEND: o_tx_valid = 1; index advances only on o_tx_valid & i_tx_ready.
- Accept at index 8: pop head; stay in SEND with index 0 if further entries remain, else go to IDLE.
REQ-021 SHALL hold o_tx_data and o_tx_valid stable while o_tx_valid & !i_tx_ready; valid SHALL never drop before acceptance.
REQ-022 SHALL produce o_tx_valid with header at the second rising edge after the retire when FIFO empty and FSM IDLE (edge E0 write, edge E1 enter SEND).
REQ-023 SHALL, when i_en falls mid-frame, complete the current frame and drain queued entries; ignored retires are not counted as drops.
REQ-024 SHALL use wrap-around read/write pointers of log2(DEPTH) bits plus an occupancy count 0..DEPTH.
REQ-025 SHALL assert o_busy combinationally as (count != 0) | (state == SEND).

Reset
REQ-026 SHALL, on i_rst_n low at any time including mid-frame, asynchronously clear: state IDLE, index 0, pointers and count 0, lost flag 0, o_drop_cnt 0, o_tx_valid 0, o_tx_data 0, o_busy 0.
REQ-027 SHALL keep FIFO data storage non-reset; no stale entry SHALL be emitted after reset.

Verification
REQ-028 Single retire: pc=0x00000100, insn=0x00500093, trap=0, ready=1 -> bytes A0 00 01 00 00 93 00 50 00; valid first high after E1; o_busy falls after the last byte.
REQ-029 Backpressure: i_tx_ready=0 for 5 cycles at byte 3 -> byte 3 held stable with valid high; stream then resumes unchanged.
REQ-030 Overflow, DEPTH=4, ready=0: 6 retires -> 4 queued, o_drop_cnt=2; next retire after drain -> header bit1 (lost)=1 (0xA2).
REQ-031 Drop counter: 300 drops -> o_drop_cnt=255; i_drop_clr coincident with a drop -> 1.
REQ-032 Reset mid-frame at byte 4 -> o_tx_valid=0 immediately; o_busy=0; no further bytes until a new retire.
REQ-033 Back-to-back: 3 retires queued, ready=1 -> 27 consecutive accepted bytes with no idle gap between frames.
